cpu_bus_core: RTL and testbench

- Register-and-bus core of the single-bus CPU datapath.
- Holds R0–R15, PC, IR, Y, HI, LO, Z_HI, Z_LO and the MDR.
- Converts the one-hot "out" strobes into a 5-bit select using an encoder sub-block, then muxes the selected source onto the shared 32-bit bus.
- The ALU sits outside: it reads bus_out and y_q, and returns zhi_d/zlo_d for the Z pair.

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/bus_reg32.sv | 20 ++
 rtl/bus_sel_encoder.sv | 23 ++
 rtl/cpu_bus_core.sv | 94 +++++++++
 tb/tb_cpu_bus_core.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the single-bus CPU register core: data width,
// GPR count and the 5-bit bus source select codes.
package cpu_bus_pkg;

   localparam int DATA_W  = 32;
   localparam int NUM_GPR = 16;

   localparam logic [4:0] SEL_R0    = 5'd0;
   localparam logic [4:0] SEL_R15   = 5'd15;
   localparam logic [4:0] SEL_HI    = 5'd16;
   localparam logic [4:0] SEL_LO    = 5'd17;
   localparam logic [4:0] SEL_ZHI   = 5'd18;
   localparam logic [4:0] SEL_ZLO   = 5'd19;
   localparam logic [4:0] SEL_PC    = 5'd20;
   localparam logic [4:0] SEL_MDR   = 5'd21;
   localparam logic [4:0] SEL_INPORT = 5'd22;
   localparam logic [4:0] SEL_C     = 5'd23;

endpackage

// File: rtl/bus_reg32.sv
// Generic enabled register with synchronous clear; clear wins over enable.
module bus_reg32
   import cpu_bus_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // Register update: clear, else load, else hold.
   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/bus_sel_encoder.sv
// 32-to-5 priority encoder (highest set bit wins, all-zero gives 0) plus a
// one-hot check used to flag a cleanly driven bus.
module bus_sel_encoder (
   input  logic [31:0] strobes,
   output logic [4:0]  sel,
   output logic        one_hot
);

   // Ascending scan so the highest set bit is the last assignment to stick.
   always_comb begin
      sel = '0;
      for (int i = 0; i < 32; i++) begin
         if (strobes[i])
            sel = 5'(i);
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   always_comb begin
      one_hot = (strobes != '0) && ((strobes & (strobes - 32'd1)) == '0);
   end

endmodule

// File: rtl/cpu_bus_core.sv
// Register-and-bus core of the single-bus CPU datapath.
// Optional build macro R0_ZERO_EN: when defined, selecting R0 drives 0 onto
// the bus (R0 still loads normally).
module cpu_bus_core
   import cpu_bus_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic [15:0]       Rin,
   input  logic [15:0]       Rout,
   input  logic              PCin,
   input  logic              IRin,
   input  logic              Yin,
   input  logic              HIin,
   input  logic              LOin,
   input  logic              Zin,
   input  logic              HIout,
   input  logic              LOout,
   input  logic              Zhighout,
   input  logic              Zlowout,
   input  logic              PCout,
   input  logic              MDRout,
   input  logic              InPortout,
   input  logic              Cout,
   input  logic              MDRin,
   input  logic              Read,
   input  logic [DATA_W-1:0] MDatain,
   input  logic [DATA_W-1:0] inport_d,
   input  logic [DATA_W-1:0] c_sext,
   input  logic [DATA_W-1:0] zhi_d,
   input  logic [DATA_W-1:0] zlo_d,
   output logic [DATA_W-1:0] bus_out,
   output logic [DATA_W-1:0] y_q,
   output logic [DATA_W-1:0] ir_q,
   output logic              bus_valid
);

   logic [DATA_W-1:0] gpr_q [NUM_GPR];
   logic [DATA_W-1:0] pc_q, hi_q, lo_q, zhi_q, zlo_q, mdr_q, mdr_d;
   logic [31:0]       strobes;
   logic [4:0]        sel;
   logic              any_strobe;

   assign strobes = {8'h00, Cout, InPortout, MDRout, PCout,
                     Zlowout, Zhighout, LOout, HIout, Rout};
   assign any_strobe = |strobes;
   assign mdr_d = Read ? MDatain : bus_out;

   bus_sel_encoder u_enc (
      .strobes (strobes),
      .sel     (sel),
      .one_hot (bus_valid)
   );

   for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
      bus_reg32 u_r (.clk(clk), .clr(clr), .en(Rin[g]), .d(bus_out), .q(gpr_q[g]));
   end

   bus_reg32 u_pc  (.clk(clk), .clr(clr), .en(PCin),  .d(bus_out), .q(pc_q));
   bus_reg32 u_ir  (.clk(clk), .clr(clr), .en(IRin),  .d(bus_out), .q(ir_q));
   bus_reg32 u_y   (.clk(clk), .clr(clr), .en(Yin),   .d(bus_out), .q(y_q));
   bus_reg32 u_hi  (.clk(clk), .clr(clr), .en(HIin),  .d(bus_out), .q(hi_q));
   bus_reg32 u_lo  (.clk(clk), .clr(clr), .en(LOin),  .d(bus_out), .q(lo_q));
   bus_reg32 u_zhi (.clk(clk), .clr(clr), .en(Zin),   .d(zhi_d),   .q(zhi_q));
   bus_reg32 u_zlo (.clk(clk), .clr(clr), .en(Zin),   .d(zlo_d),   .q(zlo_q));
   bus_reg32 u_mdr (.clk(clk), .clr(clr), .en(MDRin), .d(mdr_d),   .q(mdr_q));

   // Bus source mux; an idle bus reads 0 rather than R0 even though sel is 0.
   always_comb begin
      bus_out = '0;
      if (any_strobe) begin
         if (!sel[4]) begin
            bus_out = gpr_q[sel[3:0]];
`ifdef R0_ZERO_EN
            if (sel == SEL_R0)
               bus_out = '0;
`endif
         end else begin
            case (sel)
               SEL_HI:     bus_out = hi_q;
               SEL_LO:     bus_out = lo_q;
               SEL_ZHI:    bus_out = zhi_q;
               SEL_ZLO:    bus_out = zlo_q;
               SEL_PC:     bus_out = pc_q;
               SEL_MDR:    bus_out = mdr_q;
               SEL_INPORT: bus_out = inport_d;
               SEL_C:      bus_out = c_sext;
               default:    bus_out = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_core.sv
module tb_cpu_bus_core;

   logic        clk = 1'b0;
   logic        clr;
   logic [15:0] Rin;
   logic [23:0] strb;
   logic        PCin, IRin, Yin, HIin, LOin, Zin, MDRin, Read;
   logic [31:0] MDatain, inport_d, c_sext, zhi_d, zlo_d;
   logic [31:0] bus_out, y_q, ir_q;
   logic        bus_valid;

   int checks = 0;
   int failures = 0;

   // Reference state, named by architectural register.
   logic [31:0] m_r [16];
   logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_zhi, m_zlo, m_mdr;

   always #5 clk = ~clk;

   cpu_bus_core dut (
      .clk(clk), .clr(clr), .Rin(Rin), .Rout(strb[15:0]),
      .PCin(PCin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Zin(Zin),
      .HIout(strb[16]), .LOout(strb[17]), .Zhighout(strb[18]), .Zlowout(strb[19]),
      .PCout(strb[20]), .MDRout(strb[21]), .InPortout(strb[22]), .Cout(strb[23]),
      .MDRin(MDRin), .Read(Read), .MDatain(MDatain), .inport_d(inport_d),
      .c_sext(c_sext), .zhi_d(zhi_d), .zlo_d(zlo_d),
      .bus_out(bus_out), .y_q(y_q), .ir_q(ir_q), .bus_valid(bus_valid)
   );

   // Value the bus should carry: the highest-numbered strobed source, else 0.
   function automatic logic [31:0] exp_bus();
      logic [31:0] src [24];
      for (int i = 0; i < 16; i++) src[i] = m_r[i];
`ifdef R0_ZERO_EN
      src[0] = 32'h0;
`endif
      src[16] = m_hi;  src[17] = m_lo;  src[18] = m_zhi; src[19] = m_zlo;
      src[20] = m_pc;  src[21] = m_mdr; src[22] = inport_d; src[23] = c_sext;
      for (int i = 23; i >= 0; i--)
         if (strb[i]) return src[i];
      return 32'h0;
   endfunction

   function automatic logic exp_valid();
      return $countones(strb) == 1;
   endfunction

   task automatic idle();
      clr = 0; Rin = '0; strb = '0;
      PCin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0; Zin = 0; MDRin = 0; Read = 0;
   endtask

   // Advance one clock, updating the reference from current inputs, then idle inputs.
   task automatic tick();
      logic [31:0] b;
      b = exp_bus();
      if (clr) begin
         for (int i = 0; i < 16; i++) m_r[i] = 0;
         m_pc = 0; m_ir = 0; m_y = 0; m_hi = 0; m_lo = 0; m_zhi = 0; m_zlo = 0; m_mdr = 0;
      end else begin
         for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = b;
         if (PCin)  m_pc = b;
         if (IRin)  m_ir = b;
         if (Yin)   m_y = b;
         if (HIin)  m_hi = b;
         if (LOin)  m_lo = b;
         if (Zin)   begin m_zhi = zhi_d; m_zlo = zlo_d; end
         if (MDRin) m_mdr = Read ? MDatain : b;
      end
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic load_const(input int idx, input logic [31:0] v);
      strb = '0; strb[23] = 1; c_sext = v; Rin[idx] = 1;
      tick();
   endtask

   task automatic test_reset();
      load_const(3, 32'hDEAD_BEEF);
      strb[3] = 1; #1;
      checks++;
      if (bus_out !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL reset_preload got=%h want=%h", bus_out, 32'hDEADBEEF);
      end
      strb = '0; strb[23] = 1; c_sext = 32'h1234_5678;
      PCin = 1; Yin = 1; IRin = 1; HIin = 1; MDRin = 1; Zin = 1; zhi_d = 32'h5; zlo_d = 32'h6;
      tick();
      clr = 1;
      tick();
      for (int i = 0; i < 22; i++) begin
         strb = '0; strb[i] = 1; #1;
         checks++;
         if (bus_out !== 32'h0) begin
            failures++; $display("FAIL reset_src%0d got=%h want=0", i, bus_out);
         end
      end
      strb = '0; #1;
      checks++;
      if (bus_out !== 32'h0 || bus_valid !== 1'b0 || y_q !== 32'h0 || ir_q !== 32'h0) begin
         failures++;
         $display("FAIL reset_idle bus=%h valid=%b y=%h ir=%h want all 0", bus_out, bus_valid, y_q, ir_q);
      end
   endtask

   task automatic test_bus_transfer();
      Read = 1; MDatain = 32'h0000_0012; MDRin = 1;
      tick();
      strb[21] = 1; Rin[2] = 1;
      tick();
      strb[2] = 1; #1;
      checks++;
      if (bus_out !== 32'h12 || y_q !== m_y) begin
         failures++; $display("FAIL bus_transfer bus=%h y=%h want bus=12 y=%h", bus_out, y_q, m_y);
      end
   endtask

   task automatic test_mdr_source();
      load_const(5, 32'h55);
      strb[5] = 1; MDRin = 1; Read = 0;
      tick();
      strb[21] = 1; #1;
      checks++;
      if (bus_out !== 32'h55) begin
         failures++; $display("FAIL mdr_from_bus got=%h want=00000055", bus_out);
      end
      strb = '0; MDRin = 1; Read = 1; MDatain = 32'hA5A5_0000;
      tick();
      strb[21] = 1; #1;
      checks++;
      if (bus_out !== 32'hA5A5_0000) begin
         failures++; $display("FAIL mdr_from_mem got=%h want=a5a50000", bus_out);
      end
      strb = '0;
   endtask

   task automatic test_z_pair();
      zhi_d = 32'h1; zlo_d = 32'hFFFF_FFFE; Zin = 1;
      tick();
      strb[18] = 1; #1;
      checks++;
      if (bus_out !== 32'h1) begin
         failures++; $display("FAIL z_high got=%h want=00000001", bus_out);
      end
      strb = '0; strb[19] = 1; #1;
      checks++;
      if (bus_out !== 32'hFFFF_FFFE) begin
         failures++; $display("FAIL z_low got=%h want=fffffffe", bus_out);
      end
      strb = '0;
   endtask

   task automatic test_priority();
      strb[23] = 1; c_sext = 32'h100; PCin = 1;
      tick();
      load_const(4, 32'h4);
      strb[4] = 1; strb[20] = 1; #1;
      checks++;
      if (bus_out !== 32'h100 || bus_valid !== 1'b0) begin
         failures++; $display("FAIL prio_multi bus=%h valid=%b want 00000100/0", bus_out, bus_valid);
      end
      strb = '0; strb[23] = 1; c_sext = 32'hFFFF_FF80; #1;
      checks++;
      if (bus_out !== 32'hFFFF_FF80 || bus_valid !== 1'b1) begin
         failures++; $display("FAIL prio_cout bus=%h valid=%b want ffffff80/1", bus_out, bus_valid);
      end
      strb = '0;
   endtask

   task automatic test_back_to_back();
      // Same-register read and write keeps the old value.
      strb[5] = 1; Rin[5] = 1;
      tick();
      strb[5] = 1; #1;
      checks++;
      if (bus_out !== 32'h55) begin
         failures++; $display("FAIL rw_same got=%h want=00000055", bus_out);
      end
      // Multiple loads capture the same bus value.
      strb = '0; strb[23] = 1; c_sext = 32'hCAFE_F00D; Rin[9] = 1; Rin[11] = 1; Yin = 1; IRin = 1; LOin = 1;
      tick();
      strb[11] = 1; #1;
      checks++;
      if (bus_out !== 32'hCAFE_F00D || y_q !== 32'hCAFE_F00D || ir_q !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL multi_load bus=%h y=%h ir=%h want cafef00d", bus_out, y_q, ir_q);
      end
      strb = '0; strb[17] = 1; #1;
      checks++;
      if (bus_out !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL multi_load_lo got=%h want=cafef00d", bus_out);
      end
      strb = '0;
   endtask

   task automatic test_enable_vs_clr();
      strb[23] = 1; c_sext = 32'h77; Rin[7] = 1; clr = 1;
      tick();
      strb[7] = 1; #1;
      checks++;
      if (bus_out !== 32'h0) begin
         failures++; $display("FAIL en_vs_clr got=%h want=0", bus_out);
      end
      strb = '0; strb[11] = 1; #1;
      checks++;
      if (bus_out !== 32'h0 || y_q !== 32'h0) begin
         failures++; $display("FAIL clr_midxfer bus=%h y=%h want 0", bus_out, y_q);
      end
      strb = '0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int k;
         k = $urandom_range(0, 9);
         strb = '0;
         if (k < 6)      strb[$urandom_range(0, 23)] = 1;
         else if (k < 8) strb = 24'($urandom);
         Rin = 16'($urandom) & 16'($urandom);
         PCin = ($urandom_range(0, 3) == 0); IRin = ($urandom_range(0, 3) == 0);
         Yin = ($urandom_range(0, 3) == 0);  HIin = ($urandom_range(0, 3) == 0);
         LOin = ($urandom_range(0, 3) == 0); Zin = ($urandom_range(0, 3) == 0);
         MDRin = ($urandom_range(0, 2) == 0); Read = $urandom_range(0, 1);
         clr = ($urandom_range(0, 40) == 0);
         MDatain = $urandom; inport_d = $urandom; c_sext = $urandom;
         zhi_d = $urandom; zlo_d = $urandom;
         #1;
         checks++;
         if (bus_out !== exp_bus()) begin
            failures++; $display("FAIL rand_bus it=%0d strb=%h got=%h want=%h", n, strb, bus_out, exp_bus());
         end
         checks++;
         if (bus_valid !== exp_valid()) begin
            failures++; $display("FAIL rand_valid it=%0d strb=%h got=%b want=%b", n, strb, bus_valid, exp_valid());
         end
         checks++;
         if (y_q !== m_y || ir_q !== m_ir) begin
            failures++; $display("FAIL rand_y_ir it=%0d y=%h ir=%h want %h %h", n, y_q, ir_q, m_y, m_ir);
         end
         tick();
      end
   endtask

   initial begin
      idle();
      MDatain = 0; inport_d = 32'h1357_9BDF; c_sext = 0; zhi_d = 0; zlo_d = 0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      m_pc = 0; m_ir = 0; m_y = 0; m_hi = 0; m_lo = 0; m_zhi = 0; m_zlo = 0; m_mdr = 0;
      clr = 1;
      tick();
      test_reset();
      test_bus_transfer();
      test_mdr_source();
      test_z_pair();
      test_priority();
      test_back_to_back();
      test_enable_vs_clr();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
